// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch slice: word width, the default
// program terminator, the fetch FSM state encoding and the instruction buffer
// entry layout. Imported by fetch_if, fetch_buf and fetch_ctrl.
// No ports.
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } buf_entry_t;

    // Instruction addresses must be word aligned.
    function automatic logic pc_aligned(input logic [WORD_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_if.sv
// -----------------------------------------------------------------------------
// fetch_if
// Bundles the fetch sequencer's memory, redirect, decode-handshake and status
// signals.
//   master : the fetch sequencer (drives imem_addr, out_*, halted, fault)
//   slave  : the surrounding core / memory (drives imem_data, redirect_*,
//            out_ready)
// -----------------------------------------------------------------------------
interface fetch_if;
    import fetch_pkg::*;

    logic [WORD_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_data;
    logic              redirect_valid;
    logic [WORD_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_instr;
    logic [WORD_W-1:0] out_pc;
    logic              halted;
    logic              fault;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output halted,
        output fault
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  halted,
        input  fault
    );

endinterface

// File: rtl/fetch_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf
// Small synchronous FIFO holding fetched {pc, instr} entries for decode.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push/wdata : write an entry (ignored when full unless popping same cycle)
//   pop/rdata  : rdata is the head entry; pop removes it
//   flush      : drop every entry; wins over push in the same cycle
//   count, full, empty : occupancy status
// -----------------------------------------------------------------------------
module fetch_buf
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  buf_entry_t       wdata,
    output buf_entry_t       rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    buf_entry_t       store [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = store[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (do_push && !flush) store[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch sequencer for a single-cycle-read instruction memory.
// Owns the PC, fetches one word per cycle into fetch_buf and presents the
// buffer head to decode over valid/ready. Handles redirects, stops on the
// terminator word and raises a sticky fault on illegal fetch addresses.
//   CLK, RST_N          : clock, asynchronous active-low reset
//   bus.imem_addr/data  : memory address (= PC) and combinational read data
//   bus.redirect_*      : one-cycle PC change request
//   bus.out_*           : decode handshake (instr + its PC)
//   bus.halted          : terminator reached and buffer drained
//   bus.fault           : sticky illegal-address / misaligned-redirect flag
// -----------------------------------------------------------------------------
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter int                MEM_WORDS = 32,
    parameter int                BUF_DEPTH = 2,
    parameter logic [WORD_W-1:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic     CLK,
    input  logic     RST_N,
    fetch_if.master  bus
);

    localparam int                CNT_W    = $clog2(BUF_DEPTH) + 1;
    localparam logic [WORD_W-1:0] PC_LIMIT = WORD_W'(MEM_WORDS * 4);

    state_t            state;
    logic [WORD_W-1:0] pc;
    logic              halted_r;
    logic              fault_r;

    buf_entry_t        head;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    logic              pop;
    logic              push;
    logic              flush;
    logic              pc_legal;
    logic              is_halt;
    logic              empty_next;

    assign pc_legal = (pc < PC_LIMIT);
    assign is_halt  = (bus.imem_data == HALT_WORD);

    // Entries left over from the cycle that entered FAULT are hidden here and
    // flushed on the following edge.
    assign bus.out_valid = ~empty & (state != ST_FAULT);
    assign pop           = bus.out_valid & bus.out_ready;

    assign push = (state == ST_RUN) & ~bus.redirect_valid & (~full | pop)
                & pc_legal & ~is_halt;

    // FAULT ignores redirects but keeps the buffer empty.
    assign flush = (bus.redirect_valid & (state != ST_FAULT)) | (state == ST_FAULT);

    // Buffer will be empty after this edge; only used when no push happens.
    assign empty_next = empty | ((count == CNT_W'(1)) & pop);

    assign bus.imem_addr = pc;
    assign bus.out_instr = bus.out_valid ? head.instr : '0;
    assign bus.out_pc    = bus.out_valid ? head.pc    : '0;
    assign bus.halted    = halted_r;
    assign bus.fault     = fault_r;

    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata ('{pc: pc, instr: bus.imem_data}),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_RUN;
            pc       <= RESET_PC;
            halted_r <= 1'b0;
            fault_r  <= 1'b0;
        end else begin
            case (state)
                ST_RUN, ST_DRAIN, ST_HALT: begin
                    if (bus.redirect_valid) begin
                        halted_r <= 1'b0;
                        if (!pc_aligned(bus.redirect_pc)) begin
                            state   <= ST_FAULT;
                            fault_r <= 1'b1;
                        end else begin
                            pc    <= bus.redirect_pc;
                            state <= ST_RUN;
                        end
                    end else if (state == ST_RUN) begin
                        if (!pc_legal) begin
                            state   <= ST_FAULT;
                            fault_r <= 1'b1;
                        end else if (is_halt) begin
                            // PC parks on the terminator word.
                            if (empty_next) begin
                                state    <= ST_HALT;
                                halted_r <= 1'b1;
                            end else begin
                                state <= ST_DRAIN;
                            end
                        end else if (push) begin
                            pc <= pc + 32'd4;
                        end
                    end else if ((state == ST_DRAIN) && empty_next) begin
                        state    <= ST_HALT;
                        halted_r <= 1'b1;
                    end
                end
                default: begin
                    // ST_FAULT: sticky until reset.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Self-checking bench for fetch_ctrl. A 32-word instruction memory model feeds
// two instances (MEM_WORDS=32 and MEM_WORDS=4). Expected {pc, instr} pairs are
// queued when a scenario is set up and compared as decode accepts them.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic CLK   = 1'b0;
    logic RST_N = 1'b1;

    always #5 CLK = ~CLK;

    fetch_if bus ();
    fetch_if bus4 ();

    fetch_ctrl #(
        .RESET_PC  (32'h0000_0000),
        .MEM_WORDS (32),
        .BUF_DEPTH (2),
        .HALT_WORD (HALT)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    fetch_ctrl #(
        .RESET_PC  (32'h0000_0000),
        .MEM_WORDS (4),
        .BUF_DEPTH (2),
        .HALT_WORD (HALT)
    ) dut4 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus4)
    );

    logic [31:0] mem [0:31];

    assign bus.imem_data  = (bus.imem_addr  < 32'd128) ? mem[bus.imem_addr[6:2]]  : 32'hBAD0_BAD0;
    assign bus4.imem_data = (bus4.imem_addr < 32'd128) ? mem[bus4.imem_addr[6:2]] : 32'hBAD0_BAD0;

    int n_checks = 0;
    int n_errors = 0;

    buf_entry_t sbq  [$];
    buf_entry_t sbq4 [$];
    buf_entry_t e_mon;
    buf_entry_t e_mon4;
    bit         mon_en  = 1'b0;
    bit         mon4_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic adv();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_default();
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i);
    endtask

    task automatic load_stream();
        load_default();
        mem[0] = 32'h2008_0001;
        mem[1] = 32'h2009_0002;
        mem[2] = 32'h0109_5020;
        mem[3] = HALT;
    endtask

    task automatic exp_push(input logic [31:0] pc);
        sbq.push_back('{pc: pc, instr: mem[pc[6:2]]});
    endtask

    task automatic exp_push4(input logic [31:0] pc);
        sbq4.push_back('{pc: pc, instr: mem[pc[6:2]]});
    endtask

    // Asserts reset wherever we are in the cycle, checks outputs react at
    // once, then releases between edges so the next period is cycle 0.
    task automatic do_reset();
        RST_N = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_instr", bus.out_instr, 32'd0);
        chk("rst_out_pc",    bus.out_pc, 32'd0);
        chk("rst_halted",    32'(bus.halted), 32'd0);
        chk("rst_fault",     32'(bus.fault), 32'd0);
        chk("rst_imem_addr", bus.imem_addr, 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        #2;
        RST_N = 1'b1;
    endtask

    always @(negedge CLK) begin
        if (mon_en && RST_N && bus.out_valid && bus.out_ready) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                e_mon = sbq.pop_front();
                chk("sb_pc",    bus.out_pc,    e_mon.pc);
                chk("sb_instr", bus.out_instr, e_mon.instr);
            end
        end
        if (mon4_en && RST_N && bus4.out_valid && bus4.out_ready) begin
            if (sbq4.size() == 0) begin
                chk("sb4_unexpected_valid", 32'(bus4.out_valid), 32'd0);
            end else begin
                e_mon4 = sbq4.pop_front();
                chk("sb4_pc",    bus4.out_pc,    e_mon4.pc);
                chk("sb4_instr", bus4.out_instr, e_mon4.instr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 32'd0;
        bus.out_ready       = 1'b1;
        bus4.redirect_valid = 1'b0;
        bus4.redirect_pc    = 32'd0;
        bus4.out_ready      = 1'b1;
        load_default();
        #3;

        // ---- Streaming to terminator ----
        load_stream();
        mon_en = 1'b1;
        exp_push(32'h0); exp_push(32'h4); exp_push(32'h8);
        do_reset();
        chk("s_c0_valid", 32'(bus.out_valid), 32'd0);
        chk("s_c0_addr",  bus.imem_addr, 32'h0);
        adv(); chk("s_c1_pc", bus.out_pc, 32'h0); chk("s_c1_valid", 32'(bus.out_valid), 32'd1);
        adv(); chk("s_c2_pc", bus.out_pc, 32'h4);
        adv(); chk("s_c3_pc", bus.out_pc, 32'h8); chk("s_c3_halted", 32'(bus.halted), 32'd0);
        adv(); chk("s_c4_halted", 32'(bus.halted), 32'd1); chk("s_c4_valid", 32'(bus.out_valid), 32'd0);
        adv(); adv();
        chk("s_c6_halted", 32'(bus.halted), 32'd1);
        chk("s_sb_empty", 32'(sbq.size()), 32'd0);

        // ---- Backpressure ----
        load_stream();
        bus.out_ready = 1'b0;
        exp_push(32'h0); exp_push(32'h4); exp_push(32'h8);
        do_reset();
        chk("bp_c0_addr", bus.imem_addr, 32'h0);
        adv(); chk("bp_c1_addr", bus.imem_addr, 32'h4); chk("bp_c1_pc", bus.out_pc, 32'h0);
        for (int c = 2; c <= 5; c++) begin
            adv();
            chk("bp_hold_addr",  bus.imem_addr, 32'h8);
            chk("bp_hold_pc",    bus.out_pc, 32'h0);
            chk("bp_hold_instr", bus.out_instr, 32'h2008_0001);
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold_count", 32'(dut.u_buf.count), 32'd2);
        end
        adv(); bus.out_ready = 1'b1; chk("bp_c6_pc", bus.out_pc, 32'h0);
        adv(); chk("bp_c7_pc", bus.out_pc, 32'h4);
        adv(); chk("bp_c8_pc", bus.out_pc, 32'h8); chk("bp_c8_halted", 32'(bus.halted), 32'd0);
        adv(); chk("bp_c9_halted", 32'(bus.halted), 32'd1);
        chk("bp_sb_empty", 32'(sbq.size()), 32'd0);

        // ---- Redirect with pushes in flight, then restart from HALT ----
        load_default();
        mem[7] = HALT;
        exp_push(32'h0); exp_push(32'h4); exp_push(32'h8);
        exp_push(32'h10); exp_push(32'h14); exp_push(32'h18);
        do_reset();
        adv(); adv();
        adv(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h10;
        chk("rd_c3_pc", bus.out_pc, 32'h8);
        adv(); bus.redirect_valid = 1'b0;
        chk("rd_c4_valid", 32'(bus.out_valid), 32'd0);
        chk("rd_c4_addr",  bus.imem_addr, 32'h10);
        adv(); chk("rd_c5_pc", bus.out_pc, 32'h10); chk("rd_c5_valid", 32'(bus.out_valid), 32'd1);
        adv(); chk("rd_c6_pc", bus.out_pc, 32'h14);
        adv(); chk("rd_c7_pc", bus.out_pc, 32'h18);
        adv(); chk("rd_c8_halted", 32'(bus.halted), 32'd1);
        adv();
        for (int i = 0; i < 7; i++) exp_push(32'(i * 4));
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0;
        adv(); bus.redirect_valid = 1'b0;
        chk("rh_c10_halted", 32'(bus.halted), 32'd0);
        chk("rh_c10_valid",  32'(bus.out_valid), 32'd0);
        chk("rh_c10_addr",   bus.imem_addr, 32'h0);
        repeat (8) adv();
        chk("rh_c18_halted", 32'(bus.halted), 32'd1);
        chk("rd_sb_empty", 32'(sbq.size()), 32'd0);

        // ---- Misaligned redirect -> sticky fault ----
        load_default();
        mem[7] = HALT;
        exp_push(32'h0); exp_push(32'h4);
        do_reset();
        adv();
        adv(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h6;
        adv(); bus.redirect_valid = 1'b0;
        chk("mr_c3_fault", 32'(bus.fault), 32'd1);
        chk("mr_c3_valid", 32'(bus.out_valid), 32'd0);
        adv(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0;
        adv(); bus.redirect_valid = 1'b0;
        chk("mr_c5_fault", 32'(bus.fault), 32'd1);
        chk("mr_c5_valid", 32'(bus.out_valid), 32'd0);
        chk("mr_c5_addr",  bus.imem_addr, 32'h8);
        adv();
        chk("mr_c6_fault", 32'(bus.fault), 32'd1);
        chk("mr_sb_empty", 32'(sbq.size()), 32'd0);
        do_reset();
        chk("mr_after_rst_fault", 32'(bus.fault), 32'd0);

        // ---- Fall-through past MEM_WORDS=4 ----
        mon_en  = 1'b0;
        mon4_en = 1'b1;
        load_default();
        exp_push4(32'h0); exp_push4(32'h4); exp_push4(32'h8); exp_push4(32'hC);
        do_reset();
        adv(); adv(); adv();
        adv();
        chk("ft_c4_pc",    bus4.out_pc, 32'hC);
        chk("ft_c4_addr",  bus4.imem_addr, 32'h10);
        chk("ft_c4_fault", 32'(bus4.fault), 32'd0);
        adv();
        chk("ft_c5_fault", 32'(bus4.fault), 32'd1);
        chk("ft_c5_valid", 32'(bus4.out_valid), 32'd0);
        adv();
        chk("ft_c6_fault", 32'(bus4.fault), 32'd1);
        chk("ft_sb_empty", 32'(sbq4.size()), 32'd0);
        mon4_en = 1'b0;

        // ---- Async reset pulse mid-stream ----
        load_default();
        mem[7] = HALT;
        sbq.delete();
        mon_en = 1'b1;
        exp_push(32'h0); exp_push(32'h4); exp_push(32'h8);
        do_reset();
        adv(); adv(); adv();
        #6;
        chk("ar_pre_sb_empty", 32'(sbq.size()), 32'd0);
        for (int i = 0; i < 7; i++) exp_push(32'(i * 4));
        do_reset();
        chk("ar_c0_addr",  bus.imem_addr, 32'h0);
        chk("ar_c0_valid", 32'(bus.out_valid), 32'd0);
        repeat (8) adv();
        chk("ar_c8_halted", 32'(bus.halted), 32'd1);
        chk("ar_sb_empty", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
